multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Drives the 2-bit instruction-class select and the 11-bit ALU function code consumed by the ALU function selector. This makes it the producer end of that sel/func interface.
- Sequences FETCH/DECODE/EXEC/MEM/WB and performs a req/ack handshake with the unified memory.
- Emits datapath write enables and the retire/illegal/error strobes.

---
 rtl/multicycle_ctrl_pkg.sv | 51 +++++
 rtl/multicycle_ctrl_alu_func_dec.sv | 32 +++
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, instruction
// classes, opcode/funct values and ALU function bit positions.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_CALCU = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_SAVE  = 2'b10,
        SEL_BEQ   = 2'b11
    } sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;

    // One-hot ALU function bit positions; all-zero means ADD, bit 10 is reserved.
    localparam int unsigned FB_SUB  = 0;
    localparam int unsigned FB_AND  = 1;
    localparam int unsigned FB_OR   = 2;
    localparam int unsigned FB_XOR  = 3;
    localparam int unsigned FB_NOR  = 4;
    localparam int unsigned FB_SLT  = 5;
    localparam int unsigned FB_SLTU = 6;
    localparam int unsigned FB_SLL  = 7;
    localparam int unsigned FB_SRL  = 8;
    localparam int unsigned FB_SRA  = 9;

endpackage

// File: rtl/multicycle_ctrl_alu_func_dec.sv
// Combinational R-type funct decoder: produces the one-hot ALU function code and
// a valid flag that is low for any funct the ALU does not support.
module alu_func_dec
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned FUNC_SIZE = 11
) (
    input  logic [5:0]           funct,
    output logic [FUNC_SIZE-1:0] func,
    output logic                 valid
);

    always_comb begin
        func  = '0;
        valid = 1'b1;
        case (funct)
            FN_ADD, FN_ADDU: ;
            FN_SUB, FN_SUBU: func[FB_SUB]  = 1'b1;
            FN_AND:          func[FB_AND]  = 1'b1;
            FN_OR:           func[FB_OR]   = 1'b1;
            FN_XOR:          func[FB_XOR]  = 1'b1;
            FN_NOR:          func[FB_NOR]  = 1'b1;
            FN_SLT:          func[FB_SLT]  = 1'b1;
            FN_SLTU:         func[FB_SLTU] = 1'b1;
            FN_SLL:          func[FB_SLL]  = 1'b1;
            FN_SRL:          func[FB_SRL]  = 1'b1;
            FN_SRA:          func[FB_SRA]  = 1'b1;
            default:         valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main FETCH/DECODE/EXEC/MEM/WB control FSM for the multicycle MIPS datapath.
// Optional memory-ack watchdog with sticky bus_err: define CTRL_WATCHDOG_EN.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned FUNC_SIZE = 11,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TO_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_br,
    output logic                 reg_we,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic [1:0]           sel,
    output logic [FUNC_SIZE-1:0] func,
`ifdef CTRL_WATCHDOG_EN
    output logic                 bus_err,
`endif
    output logic                 retire,
    output logic                 illegal
);

    state_e                 state_q, state_d;
    sel_e                   cls_q, cls_d;
    logic [FUNC_SIZE-1:0]   func_q, func_d;
    logic [FUNC_SIZE-1:0]   dec_func;
    logic                   dec_valid;
    logic                   op_valid;
    logic                   wd_timeout;

    alu_func_dec #(.FUNC_SIZE(FUNC_SIZE)) u_dec (
        .funct (funct),
        .func  (dec_func),
        .valid (dec_valid)
    );

    assign op_valid = (opcode == OP_RTYPE) ? dec_valid
                    : (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ);
    assign sel  = cls_q;
    assign func = func_q;

    // Outputs are forced low while rst is high so a pending request vanishes at once.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        func_d     = func_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_br      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    if (wd_timeout) begin
                        state_d = ST_FETCH;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            ir_we   = 1'b1;
                            pc_we   = 1'b1;
                            state_d = ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (!op_valid) begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                        func_d  = '0;
                        case (opcode)
                            OP_LW:  cls_d = SEL_LOAD;
                            OP_SW:  cls_d = SEL_SAVE;
                            OP_BEQ: begin
                                cls_d          = SEL_BEQ;
                                func_d[FB_SUB] = 1'b1;
                            end
                            default: begin
                                cls_d  = SEL_CALCU;
                                func_d = dec_func;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    case (cls_q)
                        SEL_CALCU:          state_d = ST_WB;
                        SEL_LOAD, SEL_SAVE: state_d = ST_MEM;
                        default: begin
                            pc_br   = zero;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (wd_timeout) begin
                        state_d = ST_FETCH;
                    end else begin
                        mem_req = 1'b1;
                        iord    = 1'b1;
                        mem_we  = (cls_q == SEL_SAVE);
                        if (mem_ack) begin
                            if (cls_q == SEL_LOAD) begin
                                state_d = ST_WB;
                            end else begin
                                retire  = (cls_q == SEL_SAVE);
                                state_d = ST_FETCH;
                            end
                        end
                    end
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (cls_q == SEL_CALCU);
                    mem_to_reg = (cls_q == SEL_LOAD);
                    retire     = 1'b1;
                    state_d    = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cls_q   <= SEL_CALCU;
            func_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            func_q  <= func_d;
        end
    end

`ifdef CTRL_WATCHDOG_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            bus_err_q, bus_err_d;

    // Counter only runs while a request waits; any idle cycle or ack clears it.
    assign wd_timeout = (wd_q == TO_W'(TIMEOUT));
    assign bus_err    = bus_err_q;

    always_comb begin
        wd_d      = '0;
        bus_err_d = bus_err_q;
        if (wd_timeout) begin
            bus_err_d = 1'b1;
        end else if (mem_req && !mem_ack) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            bus_err_q <= bus_err_d;
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl; per-instruction activity is
// compared with a latency/class model derived from the instruction set rules.
module tb_multicycle_ctrl;

`ifdef CTRL_WATCHDOG_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode, funct;
    logic        zero, mem_ack;
    logic        mem_req, mem_we, iord, ir_we, pc_we, pc_br, reg_we, reg_dst, mem_to_reg;
    logic [1:0]  sel;
    logic [10:0] func;
    logic        retire, illegal;
`ifdef CTRL_WATCHDOG_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] cycles;
        logic [7:0] req;
        logic [7:0] iord_c;
        logic [7:0] mwe;
        logic [7:0] irwe;
        logic [7:0] pcwe;
        logic [7:0] regwe;
        logic [7:0] ret;
        logic [7:0] ill;
        logic [7:0] br;
        logic       dst;
        logic       m2r;
        logic       hung;
    } stats_t;

    stats_t      obs, exp_s;
    logic [1:0]  obs_sel;
    logic [10:0] obs_func;
    logic [1:0]  mdl_sel;
    logic [10:0] mdl_func;

    multicycle_ctrl #(.FUNC_SIZE(11), .TIMEOUT(TB_TIMEOUT), .TO_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_br      (pc_br),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .sel        (sel),
        .func       (func),
`ifdef CTRL_WATCHDOG_EN
        .bus_err    (bus_err),
`endif
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the instruction-set table.
    function automatic void model_decode(input logic [5:0] op, input logic [5:0] fn,
                                         output bit ok, output logic [1:0] cls,
                                         output logic [10:0] f);
        ok = 1'b1; cls = 2'b00; f = 11'd0;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h21)      f = 11'd0;
            else if (fn == 6'h22 || fn == 6'h23) f = 11'd1;
            else if (fn >= 6'h24 && fn <= 6'h27) f = 11'd1 << (int'(fn) - 'h24 + 1);
            else if (fn == 6'h2A)                f = 11'd1 << 5;
            else if (fn == 6'h2B)                f = 11'd1 << 6;
            else if (fn == 6'h00)                f = 11'd1 << 7;
            else if (fn == 6'h02)                f = 11'd1 << 8;
            else if (fn == 6'h03)                f = 11'd1 << 9;
            else                                 ok = 1'b0;
        end else if (op == 6'h23) cls = 2'b01;
        else if (op == 6'h2B)     cls = 2'b10;
        else if (op == 6'h04) begin cls = 2'b11; f = 11'd1; end
        else ok = 1'b0;
    endfunction

    // Expected totals for one instruction; updates the model's class/func registers.
    task automatic model_expect(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int fw, input int mw);
        bit ok; logic [1:0] cls; logic [10:0] f;
        bit has_mem, has_wb;
        model_decode(op, fn, ok, cls, f);
        exp_s = '0;
        exp_s.req = 8'(fw + 1);
        if (!ok) begin
            exp_s.cycles = 8'(fw + 2);
            exp_s.irwe = 1; exp_s.pcwe = 1; exp_s.ill = 1;
        end else begin
            mdl_sel = cls; mdl_func = f;
            has_mem = (cls == 2'b01) || (cls == 2'b10);
            has_wb  = (cls == 2'b00) || (cls == 2'b01);
            exp_s.cycles = 8'((fw + 1) + 2 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0));
            exp_s.req    = 8'((fw + 1) + (has_mem ? mw + 1 : 0));
            exp_s.iord_c = 8'(has_mem ? mw + 1 : 0);
            exp_s.mwe    = 8'((cls == 2'b10) ? mw + 1 : 0);
            exp_s.irwe = 1; exp_s.pcwe = 1; exp_s.ret = 1;
            exp_s.regwe  = 8'(has_wb ? 1 : 0);
            exp_s.br     = 8'((cls == 2'b11 && z) ? 1 : 0);
            exp_s.dst    = (cls == 2'b00);
            exp_s.m2r    = (cls == 2'b01);
        end
    endtask

    // Runs one instruction from its first FETCH cycle; memory acks after fw/mw waits.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fw, input int mw);
        int run = 0;
        int cyc = 0;
        bit done = 1'b0;
        opcode = op; funct = fn; zero = z;
        obs = '0;
        while (!done && cyc < 60) begin
            cyc++;
            if (mem_req) begin
                mem_ack = (run == (iord ? mw : fw));
                run = mem_ack ? 0 : run + 1;
            end else begin
                run = 0;
                mem_ack = 1'($urandom_range(0, 1));
            end
            #2;
            if (mem_req)         obs.req++;
            if (mem_req && iord) obs.iord_c++;
            if (mem_we)          obs.mwe++;
            if (ir_we)           obs.irwe++;
            if (pc_we)           obs.pcwe++;
            if (pc_br)           obs.br++;
            if (retire)          obs.ret++;
            if (illegal)         obs.ill++;
            if (reg_we) begin
                obs.regwe++;
                obs.dst = reg_dst;
                obs.m2r = mem_to_reg;
            end
            obs_sel = sel; obs_func = func;
            if (retire || illegal) done = 1'b1;
            @(posedge clk); #1;
        end
        obs.cycles = 8'(cyc);
        obs.hung = !done;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_ack = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        @(posedge clk); #3;
        n_checks++;
        if ({mem_req, mem_we, iord, ir_we, pc_we, pc_br, reg_we, reg_dst, mem_to_reg, retire, illegal} !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b expected 0", {mem_req, mem_we, iord, ir_we, pc_we, pc_br, reg_we, reg_dst, mem_to_reg, retire, illegal});
        end
        n_checks++;
        if (sel !== 2'b00 || func !== 11'd0) begin
            n_errors++;
            $display("FAIL reset_selfunc: got sel=%b func=%h expected 00/000", sel, func);
        end
`ifdef CTRL_WATCHDOG_EN
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_bus_err: got %b expected 0", bus_err);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0;
        mdl_sel = 2'b00; mdl_func = 11'd0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || iord !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got mem_req=%b iord=%b expected 1/0", mem_req, iord);
        end
    endtask

    task automatic test_reset_mid_mem;
        bit reached = 1'b0;
        opcode = 6'h23; funct = 6'h00;
        for (int i = 0; i < 10 && !reached; i++) begin
            if (mem_req && iord) reached = 1'b1;
            else begin
                mem_ack = mem_req;
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        n_checks++;
        if (!reached) begin
            n_errors++;
            $display("FAIL midmem_reach: got no MEM request expected one within 10 cycles");
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, iord, retire, reg_we, sel, func} !== 15'd0) begin
            n_errors++;
            $display("FAIL midmem_reset: got req=%b iord=%b ret=%b sel=%b func=%h expected all 0", mem_req, iord, retire, sel, func);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_sel = 2'b00; mdl_func = 11'd0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || iord !== 1'b0) begin
            n_errors++;
            $display("FAIL midmem_release: got mem_req=%b iord=%b expected 1/0", mem_req, iord);
        end
    endtask

    task automatic test_add;
        model_expect(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        n_checks++;
        if (obs !== exp_s) begin
            n_errors++;
            $display("FAIL add_stats: got %p expected %p", obs, exp_s);
        end
        n_checks++;
        if (obs.cycles !== 8'd4 || obs.dst !== 1'b1) begin
            n_errors++;
            $display("FAIL add_latency: got cycles=%0d reg_dst=%b expected 4/1", obs.cycles, obs.dst);
        end
        n_checks++;
        if (obs_sel !== 2'b00 || obs_func !== 11'd0) begin
            n_errors++;
            $display("FAIL add_selfunc: got %b/%h expected 00/000", obs_sel, obs_func);
        end
    endtask

    task automatic test_lw_wait;
        model_expect(6'h23, 6'h15, 1'b0, 0, 3);
        run_instr(6'h23, 6'h15, 1'b0, 0, 3);
        n_checks++;
        if (obs !== exp_s) begin
            n_errors++;
            $display("FAIL lw_stats: got %p expected %p", obs, exp_s);
        end
        n_checks++;
        if (obs.iord_c !== 8'd4 || obs.mwe !== 8'd0 || obs.m2r !== 1'b1 || obs.ret !== 8'd1) begin
            n_errors++;
            $display("FAIL lw_mem: got iord=%0d mwe=%0d m2r=%b ret=%0d expected 4/0/1/1", obs.iord_c, obs.mwe, obs.m2r, obs.ret);
        end
        n_checks++;
        if (obs_sel !== 2'b01 || obs_func !== 11'd0) begin
            n_errors++;
            $display("FAIL lw_selfunc: got %b/%h expected 01/000", obs_sel, obs_func);
        end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            model_expect(6'h04, 6'h00, 1'(z), 0, 0);
            run_instr(6'h04, 6'h00, 1'(z), 0, 0);
            n_checks++;
            if (obs !== exp_s) begin
                n_errors++;
                $display("FAIL beq_stats zero=%0d: got %p expected %p", z, obs, exp_s);
            end
            n_checks++;
            if (obs.cycles !== 8'd3 || obs.br !== 8'(z)) begin
                n_errors++;
                $display("FAIL beq_branch zero=%0d: got cycles=%0d pc_br=%0d expected 3/%0d", z, obs.cycles, obs.br, z);
            end
            n_checks++;
            if (obs_sel !== 2'b11 || obs_func !== 11'd1) begin
                n_errors++;
                $display("FAIL beq_selfunc: got %b/%h expected 11/001", obs_sel, obs_func);
            end
        end
    endtask

    task automatic test_illegal;
        logic [5:0] ops [2] = '{6'h3F, 6'h00};
        for (int k = 0; k < 2; k++) begin
            model_expect(ops[k], 6'h3F, 1'b0, 1, 0);
            run_instr(ops[k], 6'h3F, 1'b0, 1, 0);
            n_checks++;
            if (obs !== exp_s) begin
                n_errors++;
                $display("FAIL illegal_stats op=%h: got %p expected %p", ops[k], obs, exp_s);
            end
            n_checks++;
            if (obs_sel !== mdl_sel || obs_func !== mdl_func) begin
                n_errors++;
                $display("FAIL illegal_keep op=%h: got %b/%h expected %b/%h", ops[k], obs_sel, obs_func, mdl_sel, mdl_func);
            end
        end
    endtask

    task automatic test_random;
        logic [5:0] fns [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        logic [5:0] op, fn;
        logic z;
        int fw, mw;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    op = 6'h00;
                2:       op = 6'h23;
                3:       op = 6'h2B;
                4:       op = 6'h04;
                default: op = 6'($urandom_range(0, 63));
            endcase
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 12)];
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            model_expect(op, fn, z, fw, mw);
            run_instr(op, fn, z, fw, mw);
            n_checks++;
            if (obs !== exp_s) begin
                n_errors++;
                $display("FAIL rand_stats #%0d op=%h fn=%h fw=%0d mw=%0d: got %p expected %p", i, op, fn, fw, mw, obs, exp_s);
            end
            n_checks++;
            if (obs_sel !== mdl_sel || obs_func !== mdl_func) begin
                n_errors++;
                $display("FAIL rand_selfunc #%0d op=%h fn=%h: got %b/%h expected %b/%h", i, op, fn, obs_sel, obs_func, mdl_sel, mdl_func);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            model_expect(6'h2B, 6'h11, 1'b0, 0, 0);
            run_instr(6'h2B, 6'h11, 1'b0, 0, 0);
            n_checks++;
            if (obs !== exp_s || obs.cycles !== 8'd4) begin
                n_errors++;
                $display("FAIL b2b_sw #%0d: got %p expected %p", i, obs, exp_s);
            end
        end
    endtask

`ifdef CTRL_WATCHDOG_EN
    task automatic test_watchdog;
        int req_cnt = 0;
        int ret_cnt = 0;
        rst = 1'b1; mem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_sel = 2'b00; mdl_func = 11'd0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (retire) ret_cnt++;
            if (!mem_req) break;
            req_cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (req_cnt !== TB_TIMEOUT || ret_cnt !== 0) begin
            n_errors++;
            $display("FAIL wd_drop: got req_cycles=%0d retire=%0d expected %0d/0", req_cnt, ret_cnt, TB_TIMEOUT);
        end
        @(posedge clk); #3;
        n_checks++;
        if (bus_err !== 1'b1 || mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL wd_set: got bus_err=%b mem_req=%b expected 1/1", bus_err, mem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_expect(6'h00, 6'h20, 1'b0, 0, 0);
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        n_checks++;
        if (bus_err !== 1'b1 || obs !== exp_s) begin
            n_errors++;
            $display("FAIL wd_sticky: got bus_err=%b stats %p expected 1 and %p", bus_err, obs, exp_s);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wd_clear: got bus_err=%b expected 0", bus_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ack = 1'b0;
        mdl_sel = 2'b00; mdl_func = 11'd0;
        test_reset;
        test_add;
        test_lw_wait;
        test_beq;
        test_illegal;
        test_back_to_back;
        test_reset_mid_mem;
        test_random;
`ifdef CTRL_WATCHDOG_EN
        test_watchdog;
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
